// File: rtl/clk_gain_multi.sv
// clk_gain_multi: N-channel gain-clock generator, runtime half-period per channel.
// Config is shadowed and committed on clk_low rising edges so outputs never glitch.
module clk_gain_multi #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 16,
  parameter int DEF_HALF = 500,
  parameter bit DEF_MODE = 1'b1,
  parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_main,
  input  logic             clr,
  input  logic             clk_low,
  input  logic             exp_w1_de1,
  input  logic             tstamp,
  input  logic             tstamp_de,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             cfg_mode,
  output logic [N_CH-1:0]  clk_gain,
  output logic [N_CH-1:0]  rise_pulse,
  output logic [N_CH-1:0]  cfg_pend,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] L_DEF = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);

  logic             r_clk_low_de;
  logic [CNT_W-1:0] r_cnt      [N_CH];
  logic [CNT_W-1:0] r_half_act [N_CH];
  logic [CNT_W-1:0] r_half_shd [N_CH];
  logic [N_CH-1:0]  r_mode_act;
  logic [N_CH-1:0]  r_mode_shd;
  logic [N_CH-1:0]  r_gain;
  logic [N_CH-1:0]  r_rise;
  logic [N_CH-1:0]  r_pend;
  logic             r_err;

  logic             w_low_rise;
  logic             w_ts_start;
  logic             w_ts_end;
  logic             w_ch_ok;
  logic             w_wr_ok;
  logic [N_CH-1:0]  w_apply;
  logic [N_CH-1:0]  w_wsel;
  logic [N_CH-1:0]  w_gain_ns;
  logic [CNT_W-1:0] w_cnt_ns [N_CH];

  assign w_low_rise = clk_low & ~r_clk_low_de;
  assign w_ts_start = w_low_rise & tstamp & ~tstamp_de;
  assign w_ts_end   = w_low_rise & ~tstamp & tstamp_de;

  assign w_ch_ok = (32'(cfg_ch) < 32'(N_CH));
  assign w_wr_ok = cfg_we & (cfg_half != '0) & w_ch_ok;
  assign w_apply = {N_CH{w_low_rise}} & r_pend;

  always_comb begin
    w_wsel = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_wsel[i] = w_wr_ok && (cfg_ch == CH_W'(i));
    end
  end

  // Priority rules use the currently active half/mode; apply only zeroes cnt.
  always_comb begin
    w_gain_ns = r_gain;
    for (int i = 0; i < N_CH; i++) begin
      w_cnt_ns[i] = r_cnt[i] + L_ONE;
      if (exp_w1_de1 || !ch_en[i]) begin
        w_cnt_ns[i]  = '0;
        w_gain_ns[i] = 1'b0;
      end else if (r_mode_act[i] && w_ts_start) begin
        w_cnt_ns[i]  = '0;
        w_gain_ns[i] = 1'b0;
      end else if (r_mode_act[i] && w_ts_end) begin
        w_cnt_ns[i]  = r_cnt[i];
        w_gain_ns[i] = 1'b1;
      end else if (r_mode_act[i] && tstamp_de) begin
        w_cnt_ns[i]  = r_cnt[i];
      end else if (r_cnt[i] >= (r_half_act[i] - L_ONE)) begin
        w_cnt_ns[i]  = '0;
        w_gain_ns[i] = ~r_gain[i];
      end
      if (w_apply[i]) begin
        w_cnt_ns[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_main or posedge clr) begin
    if (clr) begin
      r_clk_low_de <= 1'b1;
      r_gain       <= '0;
      r_rise       <= '0;
      r_pend       <= '0;
      r_err        <= 1'b0;
      r_mode_act   <= {N_CH{DEF_MODE}};
      r_mode_shd   <= {N_CH{DEF_MODE}};
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i]      <= '0;
        r_half_act[i] <= L_DEF;
        r_half_shd[i] <= L_DEF;
      end
    end else begin
      r_clk_low_de <= clk_low;
      r_gain       <= w_gain_ns;
      r_rise       <= w_gain_ns & ~r_gain;
      r_err        <= cfg_we & ~w_wr_ok;
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= w_cnt_ns[i];
        if (w_apply[i]) begin
          r_half_act[i] <= r_half_shd[i];
          r_mode_act[i] <= r_mode_shd[i];
        end
        // A write landing with an apply refills the shadow and stays pending.
        if (w_wsel[i]) begin
          r_half_shd[i] <= cfg_half;
          r_mode_shd[i] <= cfg_mode;
          r_pend[i]     <= 1'b1;
        end else if (w_apply[i]) begin
          r_pend[i]     <= 1'b0;
        end
      end
    end
  end

  assign clk_gain   = r_gain;
  assign rise_pulse = r_rise;
  assign cfg_pend   = r_pend;
  assign cfg_err    = r_err;

endmodule

// File: tb/tb_clk_gain_multi.sv
// tb_clk_gain_multi: directed scenarios for clk_gain_multi.
// Built with DEF_HALF=5, N_CH=4, CH_W=3 so out-of-range channels are reachable.
module tb_clk_gain_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int CH_W  = 3;

  logic             clk_main = 1'b0;
  logic             clr = 1'b1;
  logic             clk_low = 1'b0;
  logic             exp_w1_de1 = 1'b0;
  logic             tstamp = 1'b0;
  logic             tstamp_de = 1'b0;
  logic [N_CH-1:0]  ch_en = '1;
  logic             cfg_we = 1'b0;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic             cfg_mode = 1'b0;
  logic [N_CH-1:0]  clk_gain;
  logic [N_CH-1:0]  rise_pulse;
  logic [N_CH-1:0]  cfg_pend;
  logic             cfg_err;

  int errs = 0;
  int checks = 0;

  clk_gain_multi #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEF_HALF(5), .DEF_MODE(1'b1), .CH_W(CH_W)
  ) dut (
    .clk_main(clk_main), .clr(clr), .clk_low(clk_low),
    .exp_w1_de1(exp_w1_de1), .tstamp(tstamp), .tstamp_de(tstamp_de),
    .ch_en(ch_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .cfg_mode(cfg_mode),
    .clk_gain(clk_gain), .rise_pulse(rise_pulse),
    .cfg_pend(cfg_pend), .cfg_err(cfg_err)
  );

  always #5 clk_main = ~clk_main;

  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  task automatic wait_rise(input int ch, input int max, output int n);
    bit found;
    found = 1'b0;
    n = -1;
    for (int k = 1; k <= max; k++) begin
      if (!found) begin
        tick();
        if (rise_pulse[ch]) begin
          found = 1'b1;
          n = k;
        end
      end
    end
  endtask

  task automatic cfg_write(input int ch, input int half, input bit mode);
    cfg_we   = 1'b1;
    cfg_ch   = CH_W'(ch);
    cfg_half = CNT_W'(half);
    cfg_mode = mode;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic low_pulse();
    clk_low = 1'b1;
    tick();
    clk_low = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    repeat (2) @(posedge clk_main);
    #1;
    checks++;
    if (clk_gain !== 4'h0) begin
      errs++; $display("FAIL reset_gain: got %h want 0", clk_gain);
    end
    checks++;
    if (rise_pulse !== 4'h0) begin
      errs++; $display("FAIL reset_rise: got %h want 0", rise_pulse);
    end
    checks++;
    if (cfg_pend !== 4'h0 || cfg_err !== 1'b0) begin
      errs++; $display("FAIL reset_cfg: got pend=%h err=%b want 0/0", cfg_pend, cfg_err);
    end
    clr = 1'b0;
    wait_rise(0, 30, n);
    checks++;
    if (n !== 5) begin
      errs++; $display("FAIL reset_first_rise: got %0d want 5", n);
    end
  endtask

  task automatic test_freerun();
    int n, hi, rises;
    logic g [20];
    logic r [20];
    cfg_write(0, 5, 1'b0);
    checks++;
    if (cfg_pend !== 4'b0001) begin
      errs++; $display("FAIL fr_pend_set: got %b want 0001", cfg_pend);
    end
    low_pulse();
    checks++;
    if (cfg_pend !== 4'b0000) begin
      errs++; $display("FAIL fr_pend_clr: got %b want 0000", cfg_pend);
    end
    wait_rise(0, 30, n);
    checks++;
    if (n < 0) begin
      errs++; $display("FAIL fr_sync: got timeout want rise");
    end
    hi = 0;
    rises = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      g[k] = clk_gain[0];
      r[k] = rise_pulse[0];
      if (g[k]) hi++;
      if (r[k]) rises++;
    end
    checks++;
    if (hi !== 10) begin
      errs++; $display("FAIL fr_high_cycles: got %0d want 10", hi);
    end
    checks++;
    if (rises !== 2) begin
      errs++; $display("FAIL fr_rise_count: got %0d want 2", rises);
    end
    checks++;
    if (g[4] !== 1'b1 || g[5] !== 1'b0) begin
      errs++; $display("FAIL fr_duty: got g4=%b g5=%b want 1/0", g[4], g[5]);
    end
    checks++;
    if (r[10] !== 1'b1) begin
      errs++; $display("FAIL fr_period: got r10=%b want 1", r[10]);
    end
  endtask

  task automatic test_shadow();
    int n;
    cfg_write(1, 3, 1'b0);
    checks++;
    if (cfg_pend !== 4'b0010) begin
      errs++; $display("FAIL sh_pend_set: got %b want 0010", cfg_pend);
    end
    wait_rise(1, 30, n);
    wait_rise(1, 30, n);
    checks++;
    if (n !== 10) begin
      errs++; $display("FAIL sh_old_period: got %0d want 10", n);
    end
    checks++;
    if (cfg_pend !== 4'b0010) begin
      errs++; $display("FAIL sh_pend_hold: got %b want 0010", cfg_pend);
    end
    low_pulse();
    checks++;
    if (cfg_pend !== 4'b0000) begin
      errs++; $display("FAIL sh_pend_clr: got %b want 0000", cfg_pend);
    end
    wait_rise(1, 30, n);
    wait_rise(1, 30, n);
    checks++;
    if (n !== 6) begin
      errs++; $display("FAIL sh_new_period: got %0d want 6", n);
    end
  endtask

  task automatic test_gated();
    int hi;
    tstamp  = 1'b1;
    clk_low = 1'b1;
    tick();
    checks++;
    if (clk_gain[2] !== 1'b0) begin
      errs++; $display("FAIL gt_start: got %b want 0", clk_gain[2]);
    end
    clk_low   = 1'b0;
    tstamp_de = 1'b1;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (clk_gain[2] !== 1'b0) hi++;
    end
    checks++;
    if (hi !== 0) begin
      errs++; $display("FAIL gt_hold: got %0d high cycles want 0", hi);
    end
    tstamp  = 1'b0;
    clk_low = 1'b1;
    tick();
    checks++;
    if (clk_gain[2] !== 1'b1 || rise_pulse[2] !== 1'b1) begin
      errs++; $display("FAIL gt_end: got g=%b r=%b want 1/1", clk_gain[2], rise_pulse[2]);
    end
    clk_low   = 1'b0;
    tstamp_de = 1'b0;
    hi = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (clk_gain[2] === 1'b1) hi++;
    end
    checks++;
    if (hi !== 4) begin
      errs++; $display("FAIL gt_high_run: got %0d want 4", hi);
    end
    tick();
    checks++;
    if (clk_gain[2] !== 1'b0) begin
      errs++; $display("FAIL gt_first_toggle: got %b want 0", clk_gain[2]);
    end
  endtask

  task automatic test_force();
    int n;
    exp_w1_de1 = 1'b1;
    tick();
    exp_w1_de1 = 1'b0;
    checks++;
    if (clk_gain !== 4'h0 || rise_pulse !== 4'h0) begin
      errs++; $display("FAIL fc_exp: got g=%h r=%h want 0/0", clk_gain, rise_pulse);
    end
    wait_rise(0, 30, n);
    checks++;
    if (n !== 5) begin
      errs++; $display("FAIL fc_exp_resume: got %0d want 5", n);
    end
    ch_en = 4'b0111;
    tick();
    checks++;
    if (clk_gain[3] !== 1'b0 || clk_gain[0] !== 1'b1) begin
      errs++; $display("FAIL fc_en_off: got g3=%b g0=%b want 0/1", clk_gain[3], clk_gain[0]);
    end
    tick();
    tick();
    checks++;
    if (clk_gain[3] !== 1'b0) begin
      errs++; $display("FAIL fc_en_hold: got %b want 0", clk_gain[3]);
    end
    ch_en = 4'b1111;
    wait_rise(3, 30, n);
    checks++;
    if (n !== 5) begin
      errs++; $display("FAIL fc_en_resume: got %0d want 5", n);
    end
  endtask

  task automatic test_errors();
    int n;
    cfg_write(0, 0, 1'b1);
    checks++;
    if (cfg_err !== 1'b1 || cfg_pend !== 4'h0) begin
      errs++; $display("FAIL er_half0: got err=%b pend=%h want 1/0", cfg_err, cfg_pend);
    end
    tick();
    checks++;
    if (cfg_err !== 1'b0) begin
      errs++; $display("FAIL er_half0_pulse: got %b want 0", cfg_err);
    end
    cfg_write(7, 4, 1'b0);
    checks++;
    if (cfg_err !== 1'b1 || cfg_pend !== 4'h0) begin
      errs++; $display("FAIL er_ch7: got err=%b pend=%h want 1/0", cfg_err, cfg_pend);
    end
    tick();
    checks++;
    if (cfg_err !== 1'b0) begin
      errs++; $display("FAIL er_ch7_pulse: got %b want 0", cfg_err);
    end
    low_pulse();
    wait_rise(0, 30, n);
    wait_rise(0, 30, n);
    checks++;
    if (n !== 10) begin
      errs++; $display("FAIL er_ch0_period: got %0d want 10", n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    cfg_write(3, 4, 1'b0);
    checks++;
    if (cfg_pend !== 4'b1000) begin
      errs++; $display("FAIL bb_pend_set: got %b want 1000", cfg_pend);
    end
    cfg_we   = 1'b1;
    cfg_ch   = 3'd3;
    cfg_half = 16'd2;
    cfg_mode = 1'b0;
    clk_low  = 1'b1;
    tick();
    cfg_we  = 1'b0;
    clk_low = 1'b0;
    checks++;
    if (cfg_pend !== 4'b1000 || cfg_err !== 1'b0) begin
      errs++; $display("FAIL bb_overlap: got pend=%b err=%b want 1000/0", cfg_pend, cfg_err);
    end
    wait_rise(3, 30, n);
    wait_rise(3, 30, n);
    checks++;
    if (n !== 8) begin
      errs++; $display("FAIL bb_old_shadow: got %0d want 8", n);
    end
    low_pulse();
    checks++;
    if (cfg_pend !== 4'b0000) begin
      errs++; $display("FAIL bb_pend_clr: got %b want 0000", cfg_pend);
    end
    wait_rise(3, 30, n);
    wait_rise(3, 30, n);
    checks++;
    if (n !== 4) begin
      errs++; $display("FAIL bb_new_shadow: got %0d want 4", n);
    end
  endtask

  task automatic test_clr();
    int n;
    wait_rise(0, 30, n);
    cfg_write(1, 7, 1'b0);
    checks++;
    if (cfg_pend !== 4'b0010 || clk_gain[0] !== 1'b1) begin
      errs++; $display("FAIL cl_setup: got pend=%b g0=%b want 0010/1", cfg_pend, clk_gain[0]);
    end
    #3;
    clr = 1'b1;
    #1;
    checks++;
    if (clk_gain !== 4'h0 || rise_pulse !== 4'h0) begin
      errs++; $display("FAIL cl_async_out: got g=%h r=%h want 0/0", clk_gain, rise_pulse);
    end
    checks++;
    if (cfg_pend !== 4'h0 || cfg_err !== 1'b0) begin
      errs++; $display("FAIL cl_async_cfg: got pend=%h err=%b want 0/0", cfg_pend, cfg_err);
    end
    #2;
    clr = 1'b0;
    wait_rise(1, 30, n);
    checks++;
    if (n !== 5) begin
      errs++; $display("FAIL cl_default_half: got %0d want 5", n);
    end
  endtask

  initial begin
    test_reset();
    test_freerun();
    test_shadow();
    test_gated();
    test_force();
    test_errors();
    test_back_to_back();
    test_clr();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
